// File: rtl/paj7620_pkg.sv
// Shared definitions for the PAJ7620 I2C target emulation.
//   state_t       : protocol FSM states of the target.
//   REG_*         : register addresses the target decodes.
//   GES_*         : bit positions inside the gesture flag byte; the
//                   master-side top decodes gesture reads with these.
package paj7620_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } state_t;

   localparam logic [7:0] REG_BANK_SEL = 8'hEF;
   localparam logic [7:0] REG_GES_FLAG = 8'h43;
   localparam logic [7:0] REG_ID_LO    = 8'h00;
   localparam logic [7:0] REG_ID_HI    = 8'h01;

   localparam int GES_UP       = 0;
   localparam int GES_DOWN     = 1;
   localparam int GES_LEFT     = 2;
   localparam int GES_RIGHT    = 3;
   localparam int GES_FORWARD  = 4;
   localparam int GES_BACKWARD = 5;
   localparam int GES_CW       = 6;
   localparam int GES_CCW      = 7;

endpackage

// File: rtl/paj7620_i2c_slave_if.sv
// I2C bus seen by the PAJ7620 target.
//   scl    : clock from the master.
//   sda_in : resolved SDA line level (wired-AND of all drivers).
//   sda_oe : 1 = target pulls SDA low, 0 = target releases SDA.
// The master side owns scl and resolves sda_in; the target only ever
// pulls low through sda_oe, never drives a high level.
interface paj7620_i2c_slave_if;
   logic scl;
   logic sda_in;
   logic sda_oe;

   modport master (output scl, output sda_in, input sda_oe);
   modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the system clock domain and flags bus events.
//   clk       : system clock.
//   scl_in    : raw SCL.        sda_in : raw SDA.
//   scl_rise  : one-cycle pulse, synchronized SCL went 0->1.
//   scl_fall  : one-cycle pulse, synchronized SCL went 1->0.
//   start_det : SDA fell while SCL stayed high.
//   stop_det  : SDA rose while SCL stayed high.
//   sda_s     : synchronized SDA level.
// The synchronizer and delay flops are deliberately not reset: they keep
// tracking the real line levels through a reset so that releasing reset
// in the middle of a transfer cannot fabricate a START or STOP.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_dly_q, scl_dly_d;
   logic                   sda_dly_q, sda_dly_d;
   logic                   scl_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_d  = scl_sync_q[SYNC_STAGES-1];
      sda_dly_d  = sda_sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_dly_q;
   assign scl_fall  = ~scl_s & scl_dly_q;
   // SCL must be high in both the current and previous sample so an SDA
   // change coincident with an SCL edge is not taken as START/STOP.
   assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/paj7620_i2c_slave.sv
// I2C target emulating the PAJ7620 gesture sensor register interface.
//   sys_clk/sys_rst : system clock, synchronous active-high reset.
//   bus             : I2C bus (scl, sda_in in; sda_oe out).
//   gesture_valid   : one-cycle strobe loading gesture_data into the flag reg.
//   wr_valid/wr_bank/wr_addr/wr_data : write report, see below.
//   busy            : high from START to STOP.
//   state_dbg       : current protocol state.
// wr_valid is a one-cycle strobe with no back-pressure: wr_bank/wr_addr/
// wr_data are valid in the cycle wr_valid is high and hold until the next
// strobe; the consumer must take them in that cycle.
module paj7620_i2c_slave
   import paj7620_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h73,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] ID_LO       = 8'h20,
   parameter logic [7:0] ID_HI       = 8'h76
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   paj7620_i2c_slave_if.slave        bus,
   input  logic                      gesture_valid,
   input  logic [7:0]                gesture_data,
   output logic                      wr_valid,
   output logic                      wr_bank,
   output logic [7:0]                wr_addr,
   output logic [7:0]                wr_data,
   output logic                      busy,
   output state_t                    state_dbg
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (sys_clk),
      .scl_in    (bus.scl),
      .sda_in    (bus.sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] ptr_q, ptr_d;
   logic       bank_q, bank_d;
   logic [7:0] ges_q, ges_d;
   logic       oe_q, oe_d;
   logic       wr_valid_q, wr_valid_d;
   logic       wr_bank_q, wr_bank_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q, busy_d;
   logic [7:0] rx_byte;
   logic [7:0] rd_val;
   logic       ges_clr;

   function automatic logic [7:0] read_map(input logic bank, input logic [7:0] addr,
                                           input logic [7:0] ges);
      logic [7:0] v;
      v = 8'h00;
      if (addr == REG_BANK_SEL) begin
         v = {7'b0, bank};
      end else if (!bank) begin
         case (addr)
            REG_ID_LO:    v = ID_LO;
            REG_ID_HI:    v = ID_HI;
            REG_GES_FLAG: v = ges;
            default:      v = 8'h00;
         endcase
      end
      return v;
   endfunction

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      bank_d     = bank_q;
      ges_d      = ges_q;
      oe_d       = oe_q;
      wr_valid_d = 1'b0;
      wr_bank_d  = wr_bank_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;
      ges_clr    = 1'b0;
      rx_byte    = {sh_q[6:0], sda_s};
      rd_val     = read_map(bank_q, ptr_q, ges_q);

      if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         oe_d      = 1'b0;
         busy_d    = 1'b1;
      end else if (scl_fall) begin
         // All SDA driving changes happen here, while SCL is low.
         case (state_q)
            ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: oe_d = 1'b1;
            ST_RDATA: begin
               if (bit_cnt_q == 3'd0) begin
                  // First fall of a read byte: snapshot the register value.
                  oe_d = ~rd_val[7];
                  tx_d = {rd_val[6:0], 1'b0};
               end else begin
                  oe_d = ~tx_q[7];
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
            default: oe_d = 1'b0;
         endcase
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR: begin
               sh_d      = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
               end
            end
            ST_ADDR_ACK: state_d = sh_q[0] ? ST_RDATA : ST_REG;
            ST_REG: begin
               sh_d      = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  ptr_d   = rx_byte;
                  state_d = ST_REG_ACK;
               end
            end
            ST_REG_ACK: state_d = ST_WDATA;
            ST_WDATA: begin
               sh_d      = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_WDATA_ACK;
               end
            end
            ST_WDATA_ACK: begin
               // Report with the bank in force before a bank-select write.
               wr_valid_d = 1'b1;
               wr_bank_d  = bank_q;
               wr_addr_d  = ptr_q;
               wr_data_d  = sh_q;
               if (ptr_q == REG_BANK_SEL) begin
                  bank_d = sh_q[0];
               end
               ptr_d   = ptr_q + 8'd1;
               state_d = ST_WDATA;
            end
            ST_RDATA: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_RDATA_ACK;
               end
            end
            ST_RDATA_ACK: begin
               ges_clr = !bank_q && (ptr_q == REG_GES_FLAG);
               if (!sda_s) begin
                  ptr_d   = ptr_q + 8'd1;
                  state_d = ST_RDATA;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
            default: ;
         endcase
      end

      // A fresh gesture beats a clear landing in the same cycle.
      if (gesture_valid) begin
         ges_d = gesture_data;
      end else if (ges_clr) begin
         ges_d = 8'h00;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         sh_q       <= 8'h00;
         tx_q       <= 8'h00;
         ptr_q      <= 8'h00;
         bank_q     <= 1'b0;
         ges_q      <= 8'h00;
         oe_q       <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         bank_q     <= bank_d;
         ges_q      <= ges_d;
         oe_q       <= oe_d;
         wr_valid_q <= wr_valid_d;
         wr_bank_q  <= wr_bank_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.sda_oe = oe_q;
   assign wr_valid   = wr_valid_q;
   assign wr_bank    = wr_bank_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/paj7620_i2c_slave.md
Name: paj7620_i2c_slave

Overview:
- Synthesizable I2C target emulating the PAJ7620 gesture sensor: the responder to the team's I2C master controller and config sequencer.
- Drives bench and FPGA loopback tests of the config and gesture-read paths with no real sensor fitted.
- Samples SCL/SDA on the system clock, keeps bank select, ID and gesture-flag registers, and reports every completed register write upstream.

Parameters:
- DEV_ADDR, 7'h73, 7-bit device address.
- SYNC_STAGES, 2, synchronizer depth for scl/sda_in (min 2).
- ID_LO, 8'h20, bank-0 reg 0x00 read value.
- ID_HI, 8'h76, bank-0 reg 0x01 read value.

Ports:
- sys_clk  in  1  system clock; must be at least 16x the SCL frequency.
- sys_rst  in  1  reset; synchronous, active-high.
- scl  in  1  I2C clock from the master.
- sda_in  in  1  SDA line level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- gesture_valid  in  1  one-cycle strobe that loads gesture_data.
- gesture_data  in  8  gesture bit mask (bit0 up, bit1 down, bit2 left, bit3 right, ...).
- wr_valid  out  1  one-cycle pulse after each ACKed data byte in a write.
- wr_bank  out  1  bank in effect for that write.
- wr_addr  out  8  register address written.
- wr_data  out  8  data byte written.
- busy  out  1  high from START detect to STOP detect.

Behaviour:
- Reset values: sda_oe=0, wr_valid=0, wr_bank=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, bank=0, gesture reg=0, reg pointer=0.
- Input conditioning: scl and sda_in pass through SYNC_STAGES flops, plus one delay flop for edge detection.
- START: SDA falls while SCL is high. Detected in any state, so a repeated START restarts at ADDR.
- STOP: SDA rises while SCL is high. Always forces IDLE and releases sda_oe.
- Data sampling and driving:
  - Data is sampled on the synchronized SCL rising edge.
  - sda_oe changes only on the synchronized SCL falling edge.
  - sda_oe latency is at most SYNC_STAGES+1 cycles after the raw SCL fall.
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits. Address match -> ADDR_ACK. Mismatch -> IGNORE, and SDA is never driven.
  - ADDR_ACK: drive 0 for the 9th bit. If R/W=0 -> REG; if R/W=1 -> RDATA with the current pointer.
  - REG: 8 bits load the pointer -> REG_ACK (ACK) -> WDATA.
  - WDATA: 8 bits -> WDATA_ACK (ACK).
    - wr_valid pulses on the 9th SCL rise.
    - Register 0xEF updates bank from data bit0.
    - Pointer increments -> WDATA.
  - RDATA: shift 8 bits MSB first. A 0 bit drives sda_oe=1; a 1 bit releases. -> RDATA_ACK.
  - RDATA_ACK: release SDA and sample the master bit on the 9th rise. ACK -> pointer+1, back to RDATA. NACK -> IGNORE.
  - IGNORE: hold until START or STOP.
- Pointer arithmetic: 8-bit, wraps 0xFF -> 0x00.
- Read map (value latched at the SCL falling edge that starts the byte):
  - 0xEF returns {7'b0, bank} in either bank.
  - Bank 0: 0x00 returns ID_LO; 0x01 returns ID_HI; 0x43 returns the gesture reg.
  - All other addresses return 0x00.
- Gesture register:
  - Loaded by gesture_valid.
  - Cleared when a byte read from bank 0 reg 0x43 completes (9th SCL rise).
  - If gesture_valid and the clear occur in the same cycle, the new gesture_data wins.
- sys_rst mid-transfer: immediate return to reset values and sda_oe released. The remainder of the transfer is ignored until the next START.

Decomposition:
- Shared package paj7620_pkg holds:
  - the state enum;
  - register address constants REG_BANK_SEL=8'hEF, REG_GES_FLAG=8'h43, REG_ID_LO=8'h00, REG_ID_HI=8'h01;
  - the gesture bit-position constants, shared with the master-side top.
- One sub-module: i2c_line_sync. It performs synchronization and edge/START/STOP detection and outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write DEV_ADDR+W, reg 0xEF, data 0x01 -> three ACKs; wr_valid once with bank=0, addr=0xEF, data=0x01; subsequent 0xEF read returns 0x01.
- Bank 0: write pointer 0x00, repeated START, read 2 bytes with ACK then NACK -> 0x20 then 0x76; SDA released after NACK; busy drops at STOP.
- gesture_valid with 0x04, then read reg 0x43 -> 0x04; second read -> 0x00.
- Address 0x72 -> 9th bit NACK (sda_oe never asserted); no wr_valid; state IGNORE until STOP.
- Burst write starting at 0xFE with 3 bytes -> wr_addr sequence 0xFE, 0xFF, 0x00.
- sys_rst asserted mid read byte while sda_oe=1 -> sda_oe=0 next cycle; next full transaction completes normally.
- gesture_valid=0x08 in the same cycle as the 0x43 read clear -> a following read returns 0x08.
